// File: rtl/rx_hdr_parse_if.sv
// Port-B rx buffer read bus plus the header/address handshake presented to the rx bus controller.
interface rx_hdr_parse_if;
  localparam int unsigned AW     = 11;
  localparam int unsigned DW     = 8;
  localparam int unsigned ADDR_W = 24;

  logic              hb_rden;
  logic [AW-1:0]     hb_raddr;
  logic [DW-1:0]     hb_rdata;
  logic              read_done;
  logic [DW-1:0]     DA;
  logic [DW-1:0]     SA_RX;
  logic [DW-1:0]     FC;
  logic [DW-1:0]     MODE;
  logic              addr_read_reg;
  logic              addr_read_done;
  logic [ADDR_W-1:0] ADDR;

  modport master (
    output hb_rden, hb_raddr, read_done, DA, SA_RX, FC, MODE, addr_read_done, ADDR,
    input  hb_rdata, addr_read_reg
  );

  modport slave (
    input  hb_rden, hb_raddr, read_done, DA, SA_RX, FC, MODE, addr_read_done, ADDR,
    output hb_rdata, addr_read_reg
  );
endinterface

// File: rtl/rx_hdr_parse.sv
// Reads a finished frame's header (DA/SA/FC/MODE, then ADDR on request) from the rx buffer
// port B and hands it to the rx bus controller; counts good and CRC-bad frames.
module rx_hdr_parse #(
  parameter int unsigned DA_OFS   = 0,
  parameter int unsigned SA_OFS   = 1,
  parameter int unsigned FC_OFS   = 2,
  parameter int unsigned MODE_OFS = 3,
  parameter int unsigned ADDR_OFS = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx_start,
  input  logic           rx_done,
  input  logic [1:0]     rx_crc_rslt,
  rx_hdr_parse_if.master bus,
  output logic [15:0]    frm_ok_cnt,
  output logic [15:0]    frm_crc_cnt
);
  localparam int unsigned AW        = 11;
  localparam int unsigned CW        = 16;
  localparam int unsigned BUF_DEPTH = 2048;

  if (DA_OFS + 2 >= BUF_DEPTH || SA_OFS + 2 >= BUF_DEPTH || FC_OFS + 2 >= BUF_DEPTH ||
      MODE_OFS + 2 >= BUF_DEPTH || ADDR_OFS + 2 >= BUF_DEPTH) begin : g_bad_ofs
    $error("rx_hdr_parse: buffer offsets do not fit the 11-bit read address");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_RD,
    S_HDR_VLD,
    S_ADDR_RD,
    S_ADDR_VLD
  } state_t;

  state_t     state;
  logic [2:0] rd_cnt;
  logic       rx_done_q;
  logic       edge_arm;
  logic       rx_edge_c;
  logic       unused_crc_c;

  // A level already high when reset releases is not a new frame, hence the arm bit.
  assign rx_edge_c    = rx_done & ~rx_done_q & edge_arm;
  assign unused_crc_c = rx_crc_rslt[1];

  function automatic logic [AW-1:0] hdr_ofs(input logic [1:0] idx);
    case (idx)
      2'd0:    hdr_ofs = AW'(DA_OFS);
      2'd1:    hdr_ofs = AW'(SA_OFS);
      2'd2:    hdr_ofs = AW'(FC_OFS);
      default: hdr_ofs = AW'(MODE_OFS);
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v == '1) ? v : v + CW'(1);
  endfunction

  // Read data returns one clock after hb_rden, so captures trail issues by one rd_cnt step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      rd_cnt             <= 3'd0;
      rx_done_q          <= 1'b0;
      edge_arm           <= 1'b0;
      bus.hb_rden        <= 1'b0;
      bus.hb_raddr       <= '0;
      bus.read_done      <= 1'b0;
      bus.addr_read_done <= 1'b0;
      bus.DA             <= '0;
      bus.SA_RX          <= '0;
      bus.FC             <= '0;
      bus.MODE           <= '0;
      bus.ADDR           <= '0;
      frm_ok_cnt         <= '0;
      frm_crc_cnt        <= '0;
    end else begin
      rx_done_q <= rx_done;
      edge_arm  <= 1'b1;
      if (rx_start) begin
        state              <= S_IDLE;
        bus.hb_rden        <= 1'b0;
        bus.read_done      <= 1'b0;
        bus.addr_read_done <= 1'b0;
      end else if (rx_edge_c) begin
        bus.read_done      <= 1'b0;
        bus.addr_read_done <= 1'b0;
        rd_cnt             <= 3'd0;
        if (rx_crc_rslt[0]) begin
          state        <= S_HDR_RD;
          bus.hb_rden  <= 1'b1;
          bus.hb_raddr <= AW'(DA_OFS);
          frm_ok_cnt   <= sat_inc(frm_ok_cnt);
        end else begin
          state       <= S_IDLE;
          bus.hb_rden <= 1'b0;
          frm_crc_cnt <= sat_inc(frm_crc_cnt);
        end
      end else begin
        case (state)
          S_HDR_RD: begin
            rd_cnt <= rd_cnt + 3'd1;
            case (rd_cnt)
              3'd1:    bus.DA    <= bus.hb_rdata;
              3'd2:    bus.SA_RX <= bus.hb_rdata;
              3'd3:    bus.FC    <= bus.hb_rdata;
              3'd4:    bus.MODE  <= bus.hb_rdata;
              default: ;
            endcase
            if (rd_cnt < 3'd3) begin
              bus.hb_rden  <= 1'b1;
              bus.hb_raddr <= hdr_ofs(rd_cnt[1:0] + 2'd1);
            end else begin
              bus.hb_rden <= 1'b0;
            end
            if (rd_cnt == 3'd4) begin
              bus.read_done <= 1'b1;
              state         <= S_HDR_VLD;
            end
          end
          S_HDR_VLD: begin
            if (bus.addr_read_reg) begin
              state        <= S_ADDR_RD;
              rd_cnt       <= 3'd0;
              bus.hb_rden  <= 1'b1;
              bus.hb_raddr <= AW'(ADDR_OFS);
            end
          end
          S_ADDR_RD: begin
            rd_cnt <= rd_cnt + 3'd1;
            case (rd_cnt)
              3'd1:    bus.ADDR[23:16] <= bus.hb_rdata;
              3'd2:    bus.ADDR[15:8]  <= bus.hb_rdata;
              3'd3:    bus.ADDR[7:0]   <= bus.hb_rdata;
              default: ;
            endcase
            if (rd_cnt < 3'd2) begin
              bus.hb_rden  <= 1'b1;
              bus.hb_raddr <= bus.hb_raddr + AW'(1);
            end else begin
              bus.hb_rden <= 1'b0;
            end
            if (rd_cnt == 3'd3) begin
              bus.addr_read_done <= 1'b1;
              state              <= S_ADDR_VLD;
            end
          end
          S_ADDR_VLD: begin
            if (!bus.addr_read_reg) begin
              bus.addr_read_done <= 1'b0;
              state              <= S_HDR_VLD;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_hdr_parse.sv
// Randomized bench for rx_hdr_parse: buffer model, read-address log and expected fields/counters.
module tb_rx_hdr_parse;
  logic        clk = 1'b0;
  logic        reset;
  logic        rx_start;
  logic        rx_done;
  logic [1:0]  rx_crc_rslt;
  logic [15:0] frm_ok_cnt;
  logic [15:0] frm_crc_cnt;

  rx_hdr_parse_if bus ();

  rx_hdr_parse dut (
    .clk         (clk),
    .reset       (reset),
    .rx_start    (rx_start),
    .rx_done     (rx_done),
    .rx_crc_rslt (rx_crc_rslt),
    .bus         (bus),
    .frm_ok_cnt  (frm_ok_cnt),
    .frm_crc_cnt (frm_crc_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:2047];
  logic [10:0] rd_log [$];

  always @(posedge clk) if (bus.hb_rden) bus.hb_rdata <= mem[bus.hb_raddr];
  always @(posedge clk) if (!reset && bus.hb_rden) rd_log.push_back(bus.hb_raddr);

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_ok   = 16'd0;
  logic [15:0] exp_crc  = 16'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] sat1(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Leaves the bench in cycle E: the next negedge lies in E+1.
  task automatic frame_rise(input logic good);
    rx_done = 1'b0;
    @(negedge clk);
    rx_done     = 1'b1;
    rx_crc_rslt = {1'($urandom_range(0, 1)), good};
    rd_log.delete();
    if (good) exp_ok = sat1(exp_ok);
    else      exp_crc = sat1(exp_crc);
  endtask

  task automatic wait_read_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.read_done && lat < 20);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_ok_cnt"}, 32'(frm_ok_cnt), 32'(exp_ok));
    check_eq({tag, "_crc_cnt"}, 32'(frm_crc_cnt), 32'(exp_crc));
  endtask

  task automatic check_hdr(input string tag);
    int ofs [4] = '{0, 1, 2, 3};
    check_eq({tag, "_DA"}, 32'(bus.DA), 32'(mem[0]));
    check_eq({tag, "_SA"}, 32'(bus.SA_RX), 32'(mem[1]));
    check_eq({tag, "_FC"}, 32'(bus.FC), 32'(mem[2]));
    check_eq({tag, "_MODE"}, 32'(bus.MODE), 32'(mem[3]));
    check_eq({tag, "_nreads"}, 32'(rd_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++)
      check_eq({tag, "_raddr"}, 32'(rd_log[i]), 32'(ofs[i]));
    check_eq({tag, "_raddr_hold"}, 32'(bus.hb_raddr), 32'd3);
  endtask

  // Drives the request in cycle A, returns at the first cycle addr_read_done is seen.
  task automatic addr_request(input string tag);
    int lat;
    @(negedge clk);
    bus.addr_read_reg = 1'b1;
    rd_log.delete();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.addr_read_done && lat < 20);
    check_eq({tag, "_addr_lat"}, 32'(lat), 32'd5);
    check_eq({tag, "_ADDR"}, 32'(bus.ADDR), {8'h00, mem[5], mem[6], mem[7]});
    check_eq({tag, "_addr_nreads"}, 32'(rd_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < rd_log.size(); i++)
      check_eq({tag, "_addr_raddr"}, 32'(rd_log[i]), 32'(5 + i));
    tick(2);
    check_eq({tag, "_addr_held"}, 32'(bus.addr_read_done), 32'd1);
    bus.addr_read_reg = 1'b0;
    @(negedge clk);
    check_eq({tag, "_addr_drop"}, 32'(bus.addr_read_done), 32'd0);
    check_eq({tag, "_rd_kept"}, 32'(bus.read_done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_read_done"}, 32'(bus.read_done), 32'd0);
    check_eq({tag, "_addr_done"}, 32'(bus.addr_read_done), 32'd0);
    check_eq({tag, "_rden"}, 32'(bus.hb_rden), 32'd0);
    check_eq({tag, "_raddr"}, 32'(bus.hb_raddr), 32'd0);
    check_eq({tag, "_hdr"}, {bus.DA, bus.SA_RX, bus.FC, bus.MODE}, 32'd0);
    check_eq({tag, "_ADDR"}, 32'(bus.ADDR), 32'd0);
    check_eq({tag, "_ok_cnt"}, 32'(frm_ok_cnt), 32'd0);
    check_eq({tag, "_crc_cnt"}, 32'(frm_crc_cnt), 32'd0);
  endtask

  task automatic load_hdr(input logic [7:0] da, sa, fc, md, a2, a1, a0);
    mem[0] = da; mem[1] = sa; mem[2] = fc; mem[3] = md;
    mem[5] = a2; mem[6] = a1; mem[7] = a0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    logic good, abort;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    reset = 1'b1; rx_start = 1'b0; rx_done = 1'b0; rx_crc_rslt = 2'b00;
    bus.addr_read_reg = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // 1: good header
    load_hdr(8'h0E, 8'h3A, 8'h60, 8'h01, 8'h12, 8'h34, 8'h56);
    frame_rise(1'b1);
    wait_read_done(lat);
    check_eq("t1_lat", 32'(lat), 32'd6);
    check_hdr("t1");
    check_counts("t1");

    // 2: address read and release
    addr_request("t2");

    // 3: CRC-bad frame aborts and is only counted
    frame_rise(1'b0);
    tick(6);
    check_eq("t3_nreads", 32'(rd_log.size()), 32'd0);
    check_eq("t3_read_done", 32'(bus.read_done), 32'd0);
    check_eq("t3_DA_kept", 32'(bus.DA), 32'h0E);
    check_counts("t3");

    // 4: rx_start during the address read, then a fresh frame
    load_hdr(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07);
    frame_rise(1'b1);
    wait_read_done(lat);
    check_hdr("t4a");
    @(negedge clk);
    bus.addr_read_reg = 1'b1;
    tick(2);
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    bus.addr_read_reg = 1'b0;
    check_eq("t4_read_done", 32'(bus.read_done), 32'd0);
    check_eq("t4_addr_done", 32'(bus.addr_read_done), 32'd0);
    check_eq("t4_rden", 32'(bus.hb_rden), 32'd0);
    tick(3);
    check_eq("t4_idle_addr_done", 32'(bus.addr_read_done), 32'd0);
    load_hdr(8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF, 8'hB0);
    frame_rise(1'b1);
    wait_read_done(lat);
    check_eq("t4_lat", 32'(lat), 32'd6);
    check_hdr("t4b");
    check_counts("t4");
    addr_request("t4b");

    // 5: rx_start beats a coincident rx_done edge; CRC counter saturates
    rx_done = 1'b0;
    @(negedge clk);
    rx_done = 1'b1; rx_crc_rslt = 2'b01; rx_start = 1'b1;
    rd_log.delete();
    @(negedge clk);
    rx_start = 1'b0;
    tick(7);
    check_eq("t5_nreads", 32'(rd_log.size()), 32'd0);
    check_eq("t5_read_done", 32'(bus.read_done), 32'd0);
    check_counts("t5");
    force dut.frm_crc_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.frm_crc_cnt;
    exp_crc = 16'hFFFE;
    frame_rise(1'b0);
    tick(2);
    check_eq("t5_crc_max", 32'(frm_crc_cnt), 32'h0000FFFF);
    frame_rise(1'b0);
    tick(2);
    check_eq("t5_crc_sat", 32'(frm_crc_cnt), 32'h0000FFFF);
    check_counts("t5b");

    // 6: async reset mid-parse, rx_done left high afterwards
    frame_rise(1'b1);
    tick(3);
    reset = 1'b1;
    #1;
    check_all_zero("t6_rst");
    exp_ok = 16'd0; exp_crc = 16'd0;
    tick(2);
    reset = 1'b0;
    rd_log.delete();
    tick(10);
    check_eq("t6_nreads", 32'(rd_log.size()), 32'd0);
    check_eq("t6_read_done", 32'(bus.read_done), 32'd0);
    check_counts("t6");

    // randomized frames against the expected-field model
    for (int it = 0; it < 40; it++) begin
      for (int b = 0; b < 8; b++) mem[b] = 8'($urandom);
      good  = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 4) == 0);
      frame_rise(good);
      if (!good) begin
        tick(4);
        check_eq("rnd_bad_nreads", 32'(rd_log.size()), 32'd0);
        check_eq("rnd_bad_read_done", 32'(bus.read_done), 32'd0);
        check_counts("rnd_bad");
      end else if (abort) begin
        tick($urandom_range(1, 8));
        rx_start = 1'b1;
        @(negedge clk);
        rx_start = 1'b0;
        check_eq("rnd_abort_read_done", 32'(bus.read_done), 32'd0);
        check_eq("rnd_abort_rden", 32'(bus.hb_rden), 32'd0);
        check_counts("rnd_abort");
      end else begin
        wait_read_done(lat);
        check_eq("rnd_lat", 32'(lat), 32'd6);
        check_hdr("rnd");
        check_counts("rnd");
        if ($urandom_range(0, 1) == 1) begin
          tick($urandom_range(0, 3));
          addr_request("rnd");
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
